// File: rtl/cla_nibble_seq_add_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package cla_nibble_seq_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_BUSY, SEQ_DONE} addseq_state_e;
  typedef enum logic {ADDOP_ADD, ADDOP_SUB} addop_e;

endpackage

// File: rtl/cla_nibble_seq_add_cla4badd.sv
// 4-bit carry-lookahead adder slice; all carries are derived from the
// generate/propagate terms and cin directly rather than rippled.
module cla4badd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_gp
      assign g[gi]   = a[gi] & b[gi];
      assign p[gi]   = a[gi] ^ b[gi];
      assign sum[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum[4] = c[4];
  assign cout   = c[4];

endmodule

// File: rtl/cla_nibble_seq_add.sv
// Multi-cycle XLEN-bit add/subtract that reuses one 4-bit CLA slice over
// XLEN/4 steps, least-significant nibble first, behind valid/ready handshakes.
module cla_nibble_seq_add
  import cla_nibble_seq_add_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_sum,
  output logic            resp_carry,
  output logic            resp_ovf,
  output logic            resp_zero
);

  localparam int NSTEP  = XLEN / NIBBLE_W;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  addseq_state_e     state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              carry_q, carry_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   sum_q, sum_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_carry_q, resp_carry_d;
  logic              resp_ovf_q, resp_ovf_d;
  logic              resp_zero_q, resp_zero_d;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W:0]   slice_sum;
  logic                slice_cout;
  logic                slice_sum_msb_unused;

  // Slice operands come only from registers, never straight from the ports.
  assign a_nib = a_q[step_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[step_q*NIBBLE_W +: NIBBLE_W];

  cla4badd u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign slice_sum_msb_unused = slice_sum[NIBBLE_W];

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    carry_d      = carry_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    resp_valid_d = resp_valid_q;
    resp_carry_d = resp_carry_q;
    resp_ovf_d   = resp_ovf_q;
    resp_zero_d  = resp_zero_q;

    if (flush) begin
      state_d      = SEQ_IDLE;
      step_d       = '0;
      resp_valid_d = 1'b0;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (req_valid) begin
            a_d          = req_a;
            b_d          = (addop_e'(req_op) == ADDOP_SUB) ? ~req_b : req_b;
            carry_d      = (addop_e'(req_op) == ADDOP_SUB);
            step_d       = '0;
            resp_carry_d = 1'b0;
            resp_ovf_d   = 1'b0;
            resp_zero_d  = 1'b0;
            state_d      = SEQ_BUSY;
          end
        end
        SEQ_BUSY: begin
          sum_d[step_q*NIBBLE_W +: NIBBLE_W] = slice_sum[NIBBLE_W-1:0];
          carry_d = slice_cout;
          if (step_q == LAST_STEP) begin
            // Flags are captured on DONE entry so they hold while resp_valid is high.
            step_d       = '0;
            state_d      = SEQ_DONE;
            resp_valid_d = 1'b1;
            resp_carry_d = slice_cout;
            resp_ovf_d   = (a_q[XLEN-1] == b_q[XLEN-1]) && (sum_d[XLEN-1] != a_q[XLEN-1]);
            resp_zero_d  = ~|sum_d;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        SEQ_DONE: begin
          if (resp_ready) begin
            state_d      = SEQ_IDLE;
            resp_valid_d = 1'b0;
          end
        end
        default: begin
          state_d      = SEQ_IDLE;
          step_d       = '0;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEQ_IDLE;
      step_q       <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_carry_q <= 1'b0;
      resp_ovf_q   <= 1'b0;
      resp_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      carry_q      <= carry_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      resp_valid_q <= resp_valid_d;
      resp_carry_q <= resp_carry_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

  assign req_ready  = (state_q == SEQ_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_sum   = sum_q;
  assign resp_carry = resp_carry_q;
  assign resp_ovf   = resp_ovf_q;
  assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_cla_nibble_seq_add.sv
// Self-checking bench: directed and random ADD/SUB against an arithmetic model,
// plus backpressure, flush and mid-operation reset recovery.
module tb_cla_nibble_seq_add;

  localparam int XLEN  = 32;
  localparam int NSTEP = XLEN / 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_op = 1'b0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic            flush = 1'b0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_sum;
  logic            resp_carry;
  logic            resp_ovf;
  logic            resp_zero;

  int tests = 0;
  int fails = 0;

  cla_nibble_seq_add #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .resp_ovf   (resp_ovf),
    .resp_zero  (resp_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic with signed range test.
  task automatic model(input bit op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] s, output bit c, output bit ovf, output bit z);
    longint sa;
    longint sb;
    longint sr;
    logic [32:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op) begin
      s  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      s    = wide[31:0];
      c    = wide[32];
      sr   = sa + sb;
    end
    ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    z   = (s == 32'd0);
  endtask

  task automatic check_resp(input string tag, input logic [31:0] es, input bit ec,
                            input bit eo, input bit ez);
    check({tag, "_valid"}, resp_valid, 32'd1);
    check({tag, "_sum"},   resp_sum,   es);
    check({tag, "_carry"}, resp_carry, ec);
    check({tag, "_ovf"},   resp_ovf,   eo);
    check({tag, "_zero"},  resp_zero,  ez);
    check({tag, "_req_ready"}, req_ready, 32'd0);
  endtask

  // Issue one op, wait (bounded) for the response, hold it for 'hold' cycles, then retire it.
  task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] es;
    bit ec, eo, ez;
    int cyc;
    model(op, a, b, es, ec, eo, ez);
    @(negedge clk);
    check("idle_req_ready", req_ready, 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = ~op; req_a = $urandom; req_b = $urandom;
    cyc = 0;
    while (!resp_valid && cyc < 4 * NSTEP) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, NSTEP);
    check_resp("resp", es, ec, eo, ez);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_resp("hold", es, ec, eo, ez);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_hs_valid", resp_valid, 32'd0);
    check("post_hs_req_ready", req_ready, 32'd1);
    $display("[TB] %s a=%h b=%h sum=%h exp=%h c=%0d ovf=%0d z=%0d lat=%0d",
             op ? "SUB" : "ADD", a, b, es, es, ec, eo, ez, cyc);
  endtask

  task automatic expect_silence(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, resp_valid, 32'd0);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [4];
    edges[0] = 32'h0000_0000; edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h8000_0000; edges[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    int cyc;
    // Reset state
    #12;
    check("rst_valid", resp_valid, 32'd0);
    check("rst_sum",   resp_sum,   32'd0);
    check("rst_carry", resp_carry, 32'd0);
    check("rst_ovf",   resp_ovf,   32'd0);
    check("rst_zero",  resp_zero,  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 32'd1);

    // Directed cases
    run_op(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(1'b1, 32'h0000_0005, 32'h0000_0007, 0);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0001, 0);
    run_op(1'b1, 32'h0000_0000, 32'h8000_0000, 0);
    run_op(1'b0, 32'h1234_5678, 32'h1111_1111, 3);

    // Flush at step 4
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'h1234_5678; req_b = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_req_ready", req_ready, 32'd1);
    expect_silence("flush_no_resp", NSTEP + 2);
    run_op(1'b0, 32'h0000_0001, 32'h0000_0002, 0);

    // Reset pulse mid-BUSY
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'h1234_5678; req_b = 32'h1111_1111;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_valid", resp_valid, 32'd0);
    check("midrst_req_ready", req_ready, 32'd1);
    rst_n = 1'b1;
    expect_silence("midrst_no_resp", NSTEP + 2);
    run_op(1'b0, 32'h0000_0001, 32'h0000_0002, 0);

    // Flush wins over acceptance in the same cycle
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept_ready", req_ready, 32'd1);
    expect_silence("flush_vs_accept_no_resp", NSTEP + 2);

    // Flush in DONE alongside the response handshake
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'h5; req_b = 32'h6;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 4 * NSTEP) begin
      @(negedge clk);
      cyc++;
    end
    check("done_flush_latency", cyc, NSTEP);
    check("done_flush_sum", resp_sum, 32'd11);
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    check("done_flush_valid", resp_valid, 32'd0);
    check("done_flush_req_ready", req_ready, 32'd1);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
